// File: rtl/iter_divider.sv
// Restoring shift-subtract divider producing one quotient bit per clock with a start/ready/done handshake.
// Define DIVIDER_SIGNED_EN to divide two's-complement operands (magnitudes divided, signs fixed on completion).
module iter_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] div_reg;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] final_q;
  logic [WIDTH-1:0] final_r;

`ifdef DIVIDER_SIGNED_EN
  logic quo_neg;
  logic rem_neg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        ready = 1'b0;
        if (count == '0) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_next = divisor_zero ? DONE : RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept       = start && ready;
  assign divisor_zero = (divisor == '0);

`ifdef DIVIDER_SIGNED_EN
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  // The shifted partial remainder is one bit wider than the operands; the borrow of the
  // subtraction doubles as the compare result, and a kept remainder always fits in WIDTH bits.
  always_comb begin
    shifted  = {rem_acc, quo_acc[WIDTH-1]};
    diff     = shifted - {1'b0, div_reg};
    fits     = ~diff[WIDTH];
    rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_acc[WIDTH-2:0], fits};
  end

`ifdef DIVIDER_SIGNED_EN
  assign final_q = quo_neg ? -quo_step : quo_step;
  assign final_r = rem_neg ? -rem_step : rem_step;
`else
  assign final_q = quo_step;
  assign final_r = rem_step;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
`endif
    end else if (accept) begin
      if (divisor_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_acc     <= '0;
        quo_acc     <= dividend_mag;
        div_reg     <= divisor_mag;
        count       <= CW'(WIDTH - 1);
        div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
        quo_neg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        rem_neg     <= dividend[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      rem_acc <= rem_step;
      quo_acc <= quo_step;
      count   <= count - 1'b1;
      if (count == '0) begin
        quotient  <= final_q;
        remainder <= final_r;
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed vectors push expected results and a monitor checks each done pulse.
module tb_iter_divider;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  iter_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .ready(ready),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Callers are positioned just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] q, input logic [7:0] r, input logic dbz,
                               input bit expect_done);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput({name, "_ready_timeout"}, 32'(ready), 32'd1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    if (expect_done) sb.push_back('{q, r, dbz, cyc + (dbz ? 0 : WIDTH), name});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) checkOutput({name, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput({e.name, "_q"},     32'(quotient),    32'(e.q));
          checkOutput({e.name, "_r"},     32'(remainder),   32'(e.r));
          checkOutput({e.name, "_dbz"},   32'(div_by_zero), 32'(e.dbz));
          checkOutput({e.name, "_cycle"}, 32'(cyc),         32'(e.cyc));
          checkOutput({e.name, "_ready"}, 32'(ready),       32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(ready),       32'd1);
    checkOutput("reset_done",  32'(done),        32'd0);
    checkOutput("reset_q",     32'(quotient),    32'd0);
    checkOutput("reset_r",     32'(remainder),   32'd0);
    checkOutput("reset_dbz",   32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100/7 with an ignored 50/5 request while busy
    applyStimulus("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    checkOutput("busy_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      @(negedge clk);
      checkOutput("busy_ready_ign", 32'(ready), 32'd0);
    end
    start = 1'b0;
    waitDone("d100_7");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_q",     32'(quotient),  32'd14);
      checkOutput("hold_r",     32'(remainder), 32'd2);
      checkOutput("hold_done",  32'(done),      32'd0);
      checkOutput("hold_ready", 32'(ready),     32'd1);
    end

    applyStimulus("d5_0",    8'd5,   8'd0,   8'hFF, 8'd5, 1'b1, 1'b1);
    waitDrain("d5_0");
    applyStimulus("d9_3",    8'd9,   8'd3,   8'd3,   8'd0, 1'b0, 1'b1);
    waitDrain("d9_3");
    applyStimulus("d255_1",  8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 1'b1);
    waitDrain("d255_1");
    applyStimulus("d7_7",    8'd7,   8'd7,   8'd1,   8'd0, 1'b0, 1'b1);
    waitDrain("d7_7");
`ifdef DIVIDER_SIGNED_EN
    applyStimulus("sm100_7", 8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0, 1'b1);
    waitDrain("sm100_7");
    applyStimulus("sm128_m1", 8'h80, 8'hFF,  8'h80,  8'h00, 1'b0, 1'b1);
    waitDrain("sm128_m1");
    applyStimulus("s100_m7", 8'd100, 8'hF9,  8'hF2,  8'h02, 1'b0, 1'b1);
    waitDrain("s100_m7");
`else
    applyStimulus("d200_13", 8'd200, 8'd13,  8'd15,  8'd5, 1'b0, 1'b1);
    waitDrain("d200_13");
`endif
    applyStimulus("d3_200",  8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 1'b1);
    waitDrain("d3_200");

    // Abort a run with reset: state clears and no done follows
    applyStimulus("abort", 8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_q",     32'(quotient),    32'd0);
    checkOutput("abort_r",     32'(remainder),   32'd0);
    checkOutput("abort_dbz",   32'(div_by_zero), 32'd0);
    checkOutput("abort_ready", 32'(ready),       32'd1);
    checkOutput("abort_done",  32'(done),        32'd0);
    repeat (12) @(negedge clk);

    // Back-to-back: second request accepted in the DONE cycle of the first
    applyStimulus("b2b_first", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    waitDone("b2b_first");
    applyStimulus("b2b_second", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
    waitDrain("b2b_second");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
